// File: rtl/freq_meter_pkg.sv
// Shared constants, converter state encoding and a decimal helper for the frequency meter.
package freq_meter_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  // 10**n, used at elaboration for the saturation limit and counter width
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock.
// state | meaning
// IDLE  | waiting for a snapshot on start
// SHIFT | W shift-add-3 iterations in progress
// DONE  | result loaded into bcd/overflow, done pulses
module bin2bcd_seq
  import freq_meter_pkg::*;
#(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  input  logic                  sat,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  done
);

  localparam int SW = 4 * DIGITS + W;
  localparam int IW = $clog2(W + 1);

  conv_state_t   state;
  logic [SW-1:0] shreg;
  logic [SW-1:0] dab;
  logic [IW-1:0] iter;
  logic          sat_q;

  // add 3 to every BCD digit that is 5 or more before the next shift
  always_comb begin
    dab = shreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (dab[W+4*d +: 4] >= 4'd5) dab[W+4*d +: 4] = dab[W+4*d +: 4] + 4'd3;
    end
  end

  // converter sequencing and registered result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CONV_IDLE;
      shreg    <= '0;
      iter     <= '0;
      sat_q    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CONV_IDLE: begin
          if (start) begin
            shreg <= {{(4*DIGITS){1'b0}}, bin};
            sat_q <= sat;
            iter  <= '0;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          shreg <= dab << 1;
          iter  <= iter + IW'(1);
          if (iter == IW'(W - 1)) state <= CONV_DONE;
        end
        CONV_DONE: begin
          // a saturated count displays as all nines
          bcd      <= sat_q ? {DIGITS{4'h9}} : shreg[W +: 4*DIGITS];
          overflow <= sat_q;
          done     <= 1'b1;
          state    <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated edge counter with background BCD conversion; counting never pauses between gates.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_BITS       = 24,
  parameter int SYNC_STAGES    = 2,
  parameter int DEFAULT_PERIOD = 12000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  signal,
  input  logic [CLK_BITS-1:0]   period,
  input  logic                  period_load,
  input  logic [1:0]            edge_mode,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  valid
);

  localparam int LIMIT = pow10(DIGITS);
  localparam int W     = $clog2(LIMIT + 1);
  localparam logic [W-1:0]        LIMIT_W = W'(LIMIT);
  // the gate must outlast a full conversion so the converter is idle at each snapshot
  localparam logic [CLK_BITS-1:0] MIN_P   = CLK_BITS'(W + 2);
  localparam logic [CLK_BITS-1:0] DEF_P   = CLK_BITS'(DEFAULT_PERIOD);

  function automatic logic [CLK_BITS-1:0] clamp_p(input logic [CLK_BITS-1:0] p);
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;
  logic                   rise, fall, det;
  logic [CLK_BITS-1:0]    period_reg, cur_p, gate_cnt;
  logic [W-1:0]           edge_cnt, edge_next, snap;
  logic                   gate_last, start;

  // synchroniser chain plus one delay flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], signal};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  // edge selection follows edge_mode in the same cycle; 11 behaves as rising
  always_comb begin
    rise = sync[SYNC_STAGES-1] & ~dly;
    fall = ~sync[SYNC_STAGES-1] & dly;
    case (edge_mode)
      EDGE_FALL: det = fall;
      EDGE_BOTH: det = rise | fall;
      default:   det = rise;
    endcase
    edge_next = (det && edge_cnt != LIMIT_W) ? edge_cnt + W'(1) : edge_cnt;
    gate_last = (gate_cnt == cur_p - CLK_BITS'(1));
  end

  // gate timing, edge accumulation and snapshot hand-off to the converter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg <= DEF_P;
      cur_p      <= clamp_p(DEF_P);
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      snap       <= '0;
      start      <= 1'b0;
    end else begin
      if (period_load) period_reg <= period;
      start <= gate_last;
      if (gate_last) begin
        snap     <= edge_next;
        edge_cnt <= '0;
        gate_cnt <= '0;
        cur_p    <= clamp_p(period_load ? period : period_reg);
      end else begin
        edge_cnt <= edge_next;
        gate_cnt <= gate_cnt + CLK_BITS'(1);
      end
    end
  end

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) u_conv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (snap),
    .sat      (snap == LIMIT_W),
    .bcd      (bcd),
    .overflow (overflow),
    .done     (valid)
  );

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed self-checking bench: a 4-digit and a 2-digit meter run side by side.
module tb_freq_meter_bcd;

  logic        clk = 1'b0;
  logic        rst4, rst2;
  logic        sig4, sig2;
  logic        sig_gen4 = 1'b0, sig_gen2 = 1'b0, sig_man4 = 1'b0, man_en4 = 1'b0;
  logic [23:0] period4, period2;
  logic        load4, load2;
  logic [1:0]  mode4, mode2;
  logic [15:0] bcd4;
  logic [7:0]  bcd2;
  logic        ovf4, ovf2, valid4, valid2;
  int          half4 = 0, half2 = 0;
  int          cyc = 0;
  int          checks = 0, fails = 0;

  assign sig4 = man_en4 ? sig_man4 : sig_gen4;
  assign sig2 = sig_gen2;

  freq_meter_bcd dut4 (
    .clk(clk), .reset_n(rst4), .signal(sig4), .period(period4), .period_load(load4),
    .edge_mode(mode4), .bcd(bcd4), .overflow(ovf4), .valid(valid4)
  );

  freq_meter_bcd #(.DIGITS(2)) dut2 (
    .clk(clk), .reset_n(rst2), .signal(sig2), .period(period2), .period_load(load2),
    .edge_mode(mode2), .bcd(bcd2), .overflow(ovf2), .valid(valid2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // square-wave generators: toggle every half cycles, idle when half is 0
  initial begin : gen4
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (half4 == 0) cnt = 0;
      else begin
        cnt++;
        if (cnt >= half4) begin sig_gen4 = ~sig_gen4; cnt = 0; end
      end
    end
  end

  initial begin : gen2
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (half2 == 0) cnt = 0;
      else begin
        cnt++;
        if (cnt >= half2) begin sig_gen2 = ~sig_gen2; cnt = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // returns at the negedge where valid is first seen high
  task automatic wait_valid(input int which, input int budget, output int t,
                            output logic [15:0] b, output logic o);
    t = -1; b = '0; o = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0) ? valid4 : valid2) begin
        t = cyc;
        b = (which == 0) ? bcd4 : {8'h00, bcd2};
        o = (which == 0) ? ovf4 : ovf2;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL valid_timeout dut%0d: no valid within %0d cycles", which, budget);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          half;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int c0;
    vecs[0] = '{2'b00, 5,  16'h0010, 1'b0};
    vecs[1] = '{2'b10, 5,  16'h0020, 1'b0};
    vecs[2] = '{2'b01, 5,  16'h0010, 1'b0};
    vecs[3] = '{2'b11, 5,  16'h0010, 1'b0};
    vecs[4] = '{2'b00, 2,  16'h0025, 1'b0};
    vecs[5] = '{2'b10, 2,  16'h0050, 1'b0};
    vecs[6] = '{2'b00, 25, 16'h0002, 1'b0};
    vecs[7] = '{2'b00, 5,  16'h0010, 1'b0};

    rst4 = 1'b0; rst2 = 1'b0;
    period4 = '0; period2 = '0; load4 = 1'b0; load2 = 1'b0;
    mode4 = 2'b00; mode2 = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_bcd4", bcd4, 0);
    chk("reset_ovf4", ovf4, 0);
    chk("reset_valid4", valid4, 0);
    chk("reset_bcd2", bcd2, 0);
    chk("reset_valid2", valid2, 0);

    @(negedge clk);
    rst4 = 1'b1; rst2 = 1'b1;
    c0 = cyc;
    half4 = 5; half2 = 2;
    period4 = 24'd100;  load4 = 1'b1;
    period2 = 24'd1000; load2 = 1'b1;
    @(negedge clk);
    load4 = 1'b0; load2 = 1'b0;

    fork
      begin : seq4
        int t, t1, t2, tp;
        logic [15:0] b;
        logic o;
        // first gate uses the default period; the load above waits for the next gate
        wait_valid(0, 12100, t, b, o);
        chk("first_latency4", t - c0, 12000 + 14 + 2);
        chk("first_bcd4", b, 16'h1200);
        chk("first_ovf4", o, 0);
        @(negedge clk);
        chk("valid_width4", valid4, 0);

        for (int i = 0; i < 8; i++) begin
          mode4 = vecs[i].mode;
          half4 = vecs[i].half;
          wait_valid(0, 300, t1, b, o);
          wait_valid(0, 300, t1, b, o);
          wait_valid(0, 300, t2, b, o);
          chk($sformatf("vec%0d_bcd", i), b, vecs[i].exp_bcd);
          chk($sformatf("vec%0d_ovf", i), o, vecs[i].exp_ovf);
          chk($sformatf("vec%0d_interval", i), t2 - t1, 100);
          @(negedge clk);
          chk($sformatf("vec%0d_valid_width", i), valid4, 0);
        end

        // reload to 200 mid-gate: current gate keeps 100, next one runs 200
        wait_valid(0, 300, tp, b, o);
        repeat (34) @(negedge clk);
        period4 = 24'd200; load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        wait_valid(0, 300, t, b, o);
        chk("reload_bcd_a", b, 16'h0010);
        chk("reload_int_a", t - tp, 100);
        tp = t;
        wait_valid(0, 300, t, b, o);
        chk("reload_bcd_b", b, 16'h0020);
        chk("reload_int_b", t - tp, 200);

        // period 3 clamps to W+2 = 16; manual edges around the boundary
        half4 = 0; man_en4 = 1'b1; sig_man4 = 1'b0; mode4 = 2'b10;
        period4 = 24'd3; load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        wait_valid(0, 300, tp, b, o);
        wait_valid(0, 300, t, b, o);
        chk("clamp_interval", t - tp, 16);
        chk("clamp_idle_bcd", b, 0);
        // change lands so it is detected in gate cycle P-1
        repeat (13) @(negedge clk);
        sig_man4 = 1'b1;
        wait_valid(0, 100, t, b, o);
        chk("bnd_last_prev", b, 0);
        wait_valid(0, 100, t, b, o);
        chk("bnd_last_counted", b, 16'h0001);
        // one cycle later: detected in cycle 0 of the following gate
        repeat (14) @(negedge clk);
        sig_man4 = 1'b0;
        wait_valid(0, 100, t, b, o);
        chk("bnd_first_prev", b, 0);
        wait_valid(0, 100, t, b, o);
        chk("bnd_first_not_ending", b, 0);
        wait_valid(0, 100, t, b, o);
        chk("bnd_first_next", b, 16'h0001);

        // reset while the converter is shifting
        repeat (5) @(negedge clk);
        rst4 = 1'b0;
        #1;
        chk("abort_bcd", bcd4, 0);
        chk("abort_ovf", ovf4, 0);
        chk("abort_valid", valid4, 0);
        repeat (3) @(negedge clk);
        rst4 = 1'b1;
        c0 = cyc;
        wait_valid(0, 12100, t, b, o);
        chk("abort_latency", t - c0, 12000 + 14 + 2);
        chk("abort_bcd_after", b, 0);
      end
      begin : seq2
        int t, t1, t2;
        logic [15:0] b;
        logic o;
        wait_valid(1, 12100, t, b, o);
        chk("first_latency2", t - c0, 12000 + 7 + 2);
        chk("first_bcd2_sat", b, 16'h0099);
        chk("first_ovf2", o, 1);
        // 250 edges per 1000-clock gate
        wait_valid(1, 1100, t1, b, o);
        wait_valid(1, 1100, t2, b, o);
        chk("ovf250_bcd", b, 16'h0099);
        chk("ovf250_ovf", o, 1);
        chk("ovf250_interval", t2 - t1, 1000);
        // 50 edges per gate
        half2 = 10;
        wait_valid(1, 1100, t1, b, o);
        wait_valid(1, 1100, t1, b, o);
        wait_valid(1, 1100, t2, b, o);
        chk("slow50_bcd", b, 16'h0050);
        chk("slow50_ovf", o, 0);
        chk("slow50_interval", t2 - t1, 1000);
        // exactly 100 edges hits the saturation value
        half2 = 5;
        wait_valid(1, 1100, t1, b, o);
        wait_valid(1, 1100, t1, b, o);
        wait_valid(1, 1100, t2, b, o);
        chk("exact100_bcd", b, 16'h0099);
        chk("exact100_ovf", o, 1);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
